cic_interpolator: RTL and testbench
===================================

# cic_interpolator

- Single-clock CIC interpolation filter with zero-stuffing upsampling and differential delay M = 1.
- Accepts signed samples at clk/INT_RATE through a valid/ready handshake.
- Produces one filtered output per clk cycle.
- Sits on the transmit/upsampling side of the CIC filter path, mirroring the decimating chain.
- Uses a clock-enable style phase counter; no derived clocks.

## Interface
- IN_WIDTH, 16, input sample width, signed two's complement.
- STAGES, 3, number of comb and integrator stages N, legal 1..6.
- INT_RATE, 4, interpolation factor R, power of 2, ≥2.
- OUT_WIDTH (localparam), IN_WIDTH + (STAGES-1)*$clog2(INT_RATE), output width.
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush of all filter state, active-high.
- in_data  input  IN_WIDTH  signed input sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  OUT_WIDTH  signed filtered sample, one per clk while running.
- out_valid  output  1  high while in RUN state.
- underrun  output  1  sticky: an input slot passed with in_valid low.

## Operation
- States:
  - IDLE (reset state): phase held at 0; in_ready=1; out_valid=0.
  - RUN: entered on the first handshake (in_valid & in_ready); leaves only on clear or reset.
- Phase counter, 0..INT_RATE-1, wraps. Accept edge in IDLE loads phase=1. In RUN it increments every cycle.
- in_ready = !clear & (state==IDLE | phase==0).
- Input slot: any RUN cycle with phase==0.
  - If in_valid=1: x = in_data. Handshake.
  - If in_valid=0: x = 0, underrun <= 1 (sticky). Filter still processes the zero sample.
- Comb chain evaluates combinationally in the slot/handshake cycle: c0 = x, ck = c(k-1) - dk.
- At the slot edge each delay dk <= c(k-1). Delays change only at slot edges.
- Upsampler register u:
  - u <= cN at a slot/handshake edge;
  - u <= 0 on every other cycle (zero-stuffing, INT_RATE-1 zeros per input).
- Integrators, updated every cycle in RUN, each registered:
  - i1 <= i1 + u;
  - ik <= ik + i(k-1);
  - out_data = iN.
- Arithmetic rules:
  - All comb, delay, u and integrator registers are OUT_WIDTH wide.
  - in_data is sign-extended; adders wrap modulo 2^OUT_WIDTH, with no saturation.
  - Wrap is correct by design because the true output always fits OUT_WIDTH.
- DC gain is INT_RATE^(STAGES-1). A constant input x settles to x*INT_RATE^(STAGES-1).
- clear=1 at an edge:
  - state <= IDLE; phase, all dk, u, all ik, out_data and underrun <= 0; out_valid <= 0.
  - clear wins over a simultaneous handshake (in_ready forced 0, sample not consumed).
- rstn low mid-operation: all state clears to IDLE values immediately, asynchronously.

## Timing
- Reset values: out_data=0, out_valid=0, underrun=0, in_ready=1 (IDLE).
- Input rate: exactly one slot per INT_RATE cycles in RUN. Consecutive slots are INT_RATE cycles apart.
- Latency: sample accepted in cycle t first affects out_data in cycle t+STAGES+1.
- out_valid rises in cycle t+1 after the first accept and stays high until clear/reset.
- underrun asserts in the cycle after the missed slot and holds until clear or reset.
- in_ready is combinational from state, phase and clear. No combinational in_valid→in_ready path.

## Test plan
- **Reset:** rstn low → out_data=0, out_valid=0, underrun=0, in_ready=1. Hold in_valid=0 for 20 cycles → still IDLE, no underrun.
- **Impulse** (N=3, R=4): send 1, then zeros every slot.
  - out_data from cycle t+4 reads 1,3,6,10,12,12,10,6,3,1, then 0 forever.
  - in_ready high exactly every 4th cycle.
- **DC step:**
  - Constant 100 → out_data settles to 1600 within 12 cycles of the first accept and stays there.
  - Constant -32768 → settles to -524288 with no wrap artifact.
- **Underrun:** impulse stream with in_valid dropped at one slot.
  - underrun=1 next cycle and stays 1.
  - Output equals the response to a zero in that slot; in_ready cadence unchanged.
- **clear mid-stream:** pulse clear with in_valid=1 at a slot.
  - Sample not consumed (in_ready=0); next cycle state IDLE, out_data=0, out_valid=0, underrun=0.
  - Next handshake restarts cleanly.
- **Async reset mid-stream:** rstn low between edges → outputs zero immediately. After release, behaviour matches a fresh run with random data against a reference model.

Source files
------------

// File: rtl/cic_interpolator.sv
// CIC interpolator: comb chain at the input rate, zero-stuffing upsampler,
// integrator chain at the clock rate. Differential delay M = 1.
module cic_interpolator #(
    parameter  int IN_WIDTH  = 16,
    parameter  int STAGES    = 3,
    parameter  int INT_RATE  = 4,
    localparam int OUT_WIDTH = IN_WIDTH + (STAGES - 1) * $clog2(INT_RATE)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 underrun
);

    localparam int PW = $clog2(INT_RATE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PW-1:0]          phase;
    logic                   accept;
    logic                   slot;
    logic [OUT_WIDTH-1:0]   x;
    logic [OUT_WIDTH-1:0]   c [STAGES+1];
    logic [OUT_WIDTH-1:0]   d [STAGES];
    logic [OUT_WIDTH-1:0]   u;
    logic [OUT_WIDTH-1:0]   integ [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = !clear && (state_q == IDLE || phase == '0);
        accept   = in_valid && in_ready;
        // In RUN every phase-0 cycle is a slot, even without a sample
        slot     = (state_q == RUN) ? in_ready : accept;
        if (clear)
            state_d = IDLE;
        else if (state_q == IDLE && accept)
            state_d = RUN;
    end

    always_comb begin
        x    = in_valid ? OUT_WIDTH'($signed(in_data)) : '0;
        c[0] = x;
        for (int k = 0; k < STAGES; k++)
            c[k+1] = c[k] - d[k];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase    <= '0;
            u        <= '0;
            underrun <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                d[k]     <= '0;
                integ[k] <= '0;
            end
        end else if (clear) begin
            phase    <= '0;
            u        <= '0;
            underrun <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                d[k]     <= '0;
                integ[k] <= '0;
            end
        end else begin
            if (state_q == RUN)
                phase <= phase + 1'b1;
            else if (accept)
                phase <= PW'(1);
            if (slot) begin
                for (int k = 0; k < STAGES; k++)
                    d[k] <= c[k];
                u <= c[STAGES];
            end else begin
                u <= '0;
            end
            if (state_q == RUN) begin
                integ[0] <= integ[0] + u;
                for (int k = 1; k < STAGES; k++)
                    integ[k] <= integ[k] + integ[k-1];
            end
            if (state_q == RUN && phase == '0 && !in_valid)
                underrun <= 1'b1;
        end
    end

    assign out_data  = integ[STAGES-1];
    assign out_valid = (state_q == RUN);

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator (N=3, R=4): table-driven impulse,
// DC steps, underrun, clear and async reset against a convolution model.
module tb_cic_interpolator;

    localparam int IW = 16;
    localparam int OW = 20;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clear;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          underrun;

    int n_chk  = 0;
    int n_fail = 0;

    // Hand-computed output-rate impulse response for N=3, R=4
    int h [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

    int xs [32];
    bit vs [32];

    typedef struct {
        logic vld;
        int   din;
        logic exp_ready;
        int   exp_out;
        logic exp_valid;
    } vec_t;

    vec_t tbl [20];

    cic_interpolator #(
        .IN_WIDTH (IW),
        .STAGES   (3),
        .INT_RATE (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    function automatic int sout();
        return int'($signed(out_data));
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Output at cycle c of a stream that starts with an accept at cycle 0
    function automatic int model(input int c);
        int acc = 0;
        for (int j = 0; 4 * j + 4 <= c; j++) begin
            int k = c - 4 - 4 * j;
            if (k <= 9 && vs[j])
                acc += xs[j] * h[k];
        end
        return acc;
    endfunction

    function automatic bit exp_und(input int c);
        bit u = 0;
        for (int j = 1; 4 * j < c; j++)
            if (!vs[j]) u = 1;
        return u;
    endfunction

    // Off-slot cycles drive in_valid=1 with junk: it must be ignored
    task automatic run_stream(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c % 4 == 0) begin
                in_valid = vs[c/4];
                in_data  = IW'(xs[c/4]);
            end else begin
                in_valid = 1'b1;
                in_data  = IW'($urandom);
            end
            #1;
            chk("stream_ready", in_ready, (c % 4 == 0));
            chk("stream_valid", out_valid, (c >= 1));
            chk("stream_underrun", underrun, exp_und(c));
            chk("stream_out", sout(), model(c));
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        #1;
        chk("clear_ready", in_ready, 0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clear_out", sout(), 0);
        chk("clear_valid", out_valid, 0);
        chk("clear_underrun", underrun, 0);
        chk("clear_idle_ready", in_ready, 1);
    endtask

    initial begin
        rstn     = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        @(negedge clk);
        chk("rst_out", sout(), 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", in_ready, 1);
        rstn = 1'b1;

        repeat (20) @(negedge clk);
        #1;
        chk("idle_ready", in_ready, 1);
        chk("idle_valid", out_valid, 0);
        chk("idle_underrun", underrun, 0);

        for (int c = 0; c < 20; c++) begin
            tbl[c].vld       = (c % 4 == 0);
            tbl[c].din       = (c == 0) ? 1 : 0;
            tbl[c].exp_ready = (c % 4 == 0);
            tbl[c].exp_out   = (c >= 4 && c <= 13) ? h[c-4] : 0;
            tbl[c].exp_valid = (c > 0);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = tbl[c].vld;
            in_data  = IW'(tbl[c].din);
            #1;
            chk("imp_ready", in_ready, tbl[c].exp_ready);
            chk("imp_out", sout(), tbl[c].exp_out);
            chk("imp_valid", out_valid, tbl[c].exp_valid);
            chk("imp_underrun", underrun, 0);
        end
        do_clear();

        for (int j = 0; j < 32; j++) begin
            xs[j] = 100;
            vs[j] = 1;
        end
        run_stream(40);
        chk("dc_pos", sout(), 1600);
        do_clear();

        for (int j = 0; j < 32; j++) xs[j] = -32768;
        run_stream(40);
        chk("dc_neg", sout(), -524288);
        do_clear();

        for (int j = 0; j < 32; j++) begin
            xs[j] = (j == 0) ? 1 : 0;
            vs[j] = (j != 2);
        end
        run_stream(28);
        chk("underrun_sticky", underrun, 1);
        do_clear();

        for (int j = 0; j < 32; j++) begin
            xs[j] = int'($signed(16'($urandom)));
            vs[j] = (j != 1);
        end
        run_stream(16);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_out", sout(), 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_underrun", underrun, 0);
        chk("arst_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rstn     = 1'b1;

        for (int j = 0; j < 32; j++) begin
            xs[j] = int'($signed(16'($urandom)));
            vs[j] = 1;
        end
        run_stream(48);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
